assoc_wt_cache: RTL and testbench
=================================

ASSOC_WT_CACHE -- requirements
Module: assoc_wt_cache

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have parameters LINE_WORDS (default 4), SETS (default 16) and WAYS (default 2), each a power of two ≥1, giving words/line, sets and associativity.
REQ-004 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-005 SHALL have CPU ports: cpu_req_valid in 1; cpu_req_ready out 1; cpu_we in 1; cpu_addr in ADDR_W; cpu_wdata in DATA_W; cpu_resp_valid out 1; cpu_rdata out DATA_W.
REQ-006 SHALL have memory ports: mem_req_valid out 1; mem_req_ready in 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rvalid in 1; mem_rdata in LINE_WORDS*DATA_W, word 0 in the LSBs.

Function
REQ-007 SHALL split cpu_addr into offset (low log2(LINE_WORDS) bits), index (next log2(SETS) bits) and tag (the remaining bits).
REQ-008 SHALL use FSM states IDLE, MISS_REQ, MISS_WAIT and WR_REQ; cpu_req_ready SHALL be 1 only in IDLE; a request is accepted on cpu_req_valid & cpu_req_ready.
REQ-009 SHALL complete a read hit accepted at cycle T with cpu_resp_valid=1 for one cycle at T+1, cpu_rdata holding the hit word; no memory request; state remains IDLE.
REQ-010 SHALL, on a read miss, enter MISS_REQ and drive mem_req_valid=1, mem_we=0, mem_addr=line-aligned address (offset zeroed) until mem_req_ready, then enter MISS_WAIT.
REQ-011 SHALL, in MISS_WAIT on mem_rvalid at cycle M: write the line into the victim way, set tag and valid, pulse cpu_resp_valid at M+1 with the requested word, and return to IDLE.
REQ-012 SHALL select the victim as the lowest-numbered invalid way, else the set's round-robin pointer; after any fill, that pointer becomes (filled way+1) mod WAYS.
REQ-013 SHALL handle writes write-through, no-allocate: a write hit updates the cached word at T+1; a write miss leaves the arrays unchanged; both enter WR_REQ.
REQ-014 SHALL, in WR_REQ, drive mem_req_valid=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata until mem_req_ready, then pulse cpu_resp_valid for 1 cycle (cpu_rdata=0) and return to IDLE.
REQ-015 SHALL ignore mem_rvalid outside MISS_WAIT and mem_req_ready when mem_req_valid=0.
REQ-016 SHALL hold all mem_* outputs stable while mem_req_valid=1 and mem_req_ready=0.

Reset
REQ-017 SHALL, while rst=1, clear all valid bits and round-robin pointers, force state IDLE, and drive cpu_resp_valid, cpu_rdata, mem_req_valid, mem_we, mem_addr and mem_wdata to 0.
REQ-018 SHALL abandon any miss or write in flight when rst asserts; after release, a late mem_rvalid SHALL be ignored.

Configuration
REQ-019 SHALL, with macro ASSOC_WT_CACHE_STATS_EN defined, provide outputs hit_cnt and miss_cnt, 32 bits each, saturating at all-ones, cleared by rst, incremented once per accepted read or write hit/miss.
REQ-020 SHALL, without ASSOC_WT_CACHE_STATS_EN, have neither these ports nor their counters.

Structure
REQ-021 SHALL place the FSM state encoding and field-width derivation helpers (offset/index/tag widths) in shared package cache_pkg.
REQ-022 SHALL implement per-way tag/valid/data storage in one sub-module, cache_way_array, instantiated WAYS times.

Verification (default parameters; offset [1:0], index [5:2], tag [9:6])
REQ-023 Read after reset:
- Read 0x025 -> mem_addr=0x024, mem_we=0.
- Supply mem_rdata={D3,D2,D1,D0} -> cpu_rdata=D1 at M+1.
- Read 0x025 again -> hit at T+1, no mem_req_valid.
REQ-024 Write hit: after REQ-023, write 0x026=0xDEADBEEF -> mem write with addr 0x026, data 0xDEADBEEF; read 0x026 -> hit, 0xDEADBEEF.
REQ-025 Write miss: write 0x3F0=0x12345678 -> mem write issued; read 0x3F0 -> miss with mem_addr=0x3F0.
REQ-026 Conflict:
- Read 0x000 then 0x040 -> fill way0 then way1.
- Read 0x080 -> fills way0.
- Read 0x040 -> hit; read 0x000 -> miss.
REQ-027 Reset in MISS_WAIT: pulse rst -> mem_req_valid=0, state IDLE; later mem_rvalid ignored; re-reading the same address misses.
REQ-028 Stats, with ASSOC_WT_CACHE_STATS_EN defined: after REQ-023 -> hit_cnt=1, miss_cnt=1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative write-through cache:
// controller state encoding and address field-width helpers.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    WR_REQ    = 2'd3
  } cache_state_e;

  // Width of a field selecting one of n items; never narrower than 1 bit
  // so degenerate (n == 1) configurations still produce legal vectors.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned off_w(input int unsigned line_words);
    return sel_w(line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return sel_w(sets);
  endfunction

  function automatic int unsigned way_w(input int unsigned ways);
    return sel_w(ways);
  endfunction

  // Tag takes whatever address bits remain above offset and index.
  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned line_words,
                                        input int unsigned sets);
    int t;
    t = int'(addr_w) - int'($clog2(line_words)) - int'($clog2(sets));
    return (t < 1) ? 1 : int'(t);
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: per-set valid bit, tag and full line of data.
// Reads are combinational at idx; fills replace a whole line, word writes
// patch a single word of an already resident line.
module cache_way_array #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 16,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned OFF_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IDX_W-1:0]             idx,
  input  logic [OFF_W-1:0]             off,
  output logic                         rd_valid,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [LINE_WORDS*DATA_W-1:0] rd_line,
  input  logic                         fill_en,
  input  logic [TAG_W-1:0]             fill_tag,
  input  logic [LINE_WORDS*DATA_W-1:0] fill_line,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data
);

  logic [SETS-1:0]              valid_q;
  logic [TAG_W-1:0]             tag_q  [SETS];
  logic [LINE_WORDS*DATA_W-1:0] line_q [SETS];

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = line_q[idx];

  // Valid bits are the only state that reset must clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage: line fill or single-word write-hit update.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      line_q[idx] <= fill_line;
    end else if (wr_en) begin
      line_q[idx][off*DATA_W +: DATA_W] <= wr_data;
    end
  end

endmodule

// File: rtl/assoc_wt_cache.sv
// Set-associative, write-through, no-write-allocate cache controller.
// Read hits answer one cycle after acceptance; misses fetch a full line
// into the victim way (first invalid, else per-set round-robin).
// Optional hit/miss counters: define ASSOC_WT_CACHE_STATS_EN.
import cache_pkg::*;

module assoc_wt_cache #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 16,
  parameter int unsigned WAYS       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req_valid,
  output logic                         cpu_req_ready,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic                         cpu_resp_valid,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_rvalid,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_rdata
`ifdef ASSOC_WT_CACHE_STATS_EN
  ,
  output logic [31:0]                  hit_cnt,
  output logic [31:0]                  miss_cnt
`endif
);

  localparam int unsigned OFF_W  = off_w(LINE_WORDS);
  localparam int unsigned IDX_W  = idx_w(SETS);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, LINE_WORDS, SETS);
  localparam int unsigned WAY_W  = way_w(WAYS);
  localparam int unsigned LINE_W = LINE_WORDS * DATA_W;

  cache_state_e       state;
  logic [ADDR_W-1:0]  req_addr;
  logic               accept;

  logic [ADDR_W-1:0]  lu_addr;
  logic [OFF_W-1:0]   lu_off;
  logic [IDX_W-1:0]   lu_idx;
  logic [TAG_W-1:0]   lu_tag;

  logic               way_valid [WAYS];
  logic [TAG_W-1:0]   way_tag   [WAYS];
  logic [LINE_W-1:0]  way_line  [WAYS];
  logic [WAYS-1:0]    way_hit;
  logic [WAYS-1:0]    way_fill;
  logic [WAYS-1:0]    way_wr;

  logic               hit;
  logic [DATA_W-1:0]  hit_word;
  logic [DATA_W-1:0]  fill_word;
  logic [WAY_W-1:0]   victim;
  logic [WAY_W-1:0]   rr_next;
  logic [WAY_W-1:0]   rr_q [SETS];
  logic               fill_now;

  assign cpu_req_ready = (state == IDLE);
  assign accept        = cpu_req_valid & cpu_req_ready;

  // The arrays are indexed by the live CPU address while idle and by the
  // captured request address while a miss or write is in flight; fills
  // and write-hit patches share that single index.
  assign lu_addr  = (state == IDLE) ? cpu_addr : req_addr;
  assign lu_off   = OFF_W'(lu_addr % LINE_WORDS);
  assign lu_idx   = IDX_W'((lu_addr / LINE_WORDS) % SETS);
  assign lu_tag   = TAG_W'(lu_addr / (LINE_WORDS * SETS));
  assign fill_now = (state == MISS_WAIT) & mem_rvalid;
  assign fill_word = mem_rdata[lu_off*DATA_W +: DATA_W];
  assign rr_next  = WAY_W'((int'(victim) + 1) % WAYS);

  genvar g;
  generate
    for (g = 0; g < WAYS; g++) begin : g_way
      assign way_fill[g] = fill_now & (victim == WAY_W'(g));
      assign way_wr[g]   = accept & cpu_we & way_hit[g];

      cache_way_array #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS),
        .TAG_W      (TAG_W),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W)
      ) u_way (
        .clk       (clk),
        .rst       (rst),
        .idx       (lu_idx),
        .off       (lu_off),
        .rd_valid  (way_valid[g]),
        .rd_tag    (way_tag[g]),
        .rd_line   (way_line[g]),
        .fill_en   (way_fill[g]),
        .fill_tag  (lu_tag),
        .fill_line (mem_rdata),
        .wr_en     (way_wr[g]),
        .wr_data   (cpu_wdata)
      );
    end
  endgenerate

  // Tag compare across all ways and selection of the hit word.
  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    way_hit  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == lu_tag)) begin
        way_hit[w] = 1'b1;
        hit        = 1'b1;
        hit_word   = way_line[w][lu_off*DATA_W +: DATA_W];
      end
    end
  end

  // Victim choice: lowest-numbered invalid way, otherwise round-robin.
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = rr_q[lu_idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !way_valid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  // Controller FSM with registered CPU/memory outputs and replacement state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      req_addr       <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      mem_req_valid  <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_addr <= cpu_addr;
            if (cpu_we) begin
              state         <= WR_REQ;
              mem_req_valid <= 1'b1;
              mem_we        <= 1'b1;
              mem_addr      <= cpu_addr;
              mem_wdata     <= cpu_wdata;
            end else if (hit) begin
              cpu_resp_valid <= 1'b1;
              cpu_rdata      <= hit_word;
            end else begin
              state         <= MISS_REQ;
              mem_req_valid <= 1'b1;
              mem_we        <= 1'b0;
              mem_addr      <= cpu_addr & ~ADDR_W'(LINE_WORDS - 1);
            end
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (mem_rvalid) begin
            rr_q[lu_idx]   <= rr_next;
            cpu_resp_valid <= 1'b1;
            cpu_rdata      <= fill_word;
            state          <= IDLE;
          end
        end
        WR_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            mem_we         <= 1'b0;
            cpu_resp_valid <= 1'b1;
            cpu_rdata      <= '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ASSOC_WT_CACHE_STATS_EN
  // Saturating hit/miss counters, one event per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_assoc_wt_cache.sv
// Self-checking bench for assoc_wt_cache (default parameters).
// Reference: a flat word-addressed memory plus a per-set residency model;
// because the cache is write-through, every read must return the memory word.
module tb_assoc_wt_cache;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int NS = 16;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_req_valid;
  logic            cpu_req_ready;
  logic            cpu_we;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic            cpu_resp_valid;
  logic [DW-1:0]   cpu_rdata;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_rvalid;
  logic [LW*DW-1:0] mem_rdata;
`ifdef ASSOC_WT_CACHE_STATS_EN
  logic [31:0]     hit_cnt;
  logic [31:0]     miss_cnt;
`endif

  always #5 clk = ~clk;

  assoc_wt_cache #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .LINE_WORDS (LW),
    .SETS       (NS),
    .WAYS       (NW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_rdata      (cpu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata)
`ifdef ASSOC_WT_CACHE_STATS_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_model [1024];
  bit          m_valid [NS][NW];
  int          m_tag   [NS][NW];
  int          m_rr    [NS];
  int          exp_hits;
  int          exp_misses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hit(input int addr);
    int s = (addr / LW) % NS;
    int t = addr / (LW * NS);
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_fill(input int addr);
    int s = (addr / LW) % NS;
    int v = -1;
    for (int w = 0; w < NW; w++)
      if (v < 0 && !m_valid[s][w]) v = w;
    if (v < 0) v = m_rr[s];
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = addr / (LW * NS);
    m_rr[s]       = (v + 1) % NW;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_tag[s][w]   = 0;
      end
    end
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  task automatic drive_line(input int addr);
    int base = addr & ~(LW - 1);
    for (int w = 0; w < LW; w++) mem_rdata[w*DW +: DW] = mem_model[base + w];
  endtask

  // One complete CPU transaction including the memory-side responder.
  task automatic do_req(input bit we, input int addr, input logic [31:0] wd);
    bit hit;
    int exp_addr;
    int stall;
    hit = model_hit(addr);
    if (hit) exp_hits++; else exp_misses++;
    exp_addr = we ? addr : (addr & ~(LW - 1));

    @(negedge clk);
    check("req_ready", 32'(cpu_req_ready), 32'd1);
    cpu_req_valid = 1'b1;
    cpu_we        = we;
    cpu_addr      = AW'(addr);
    cpu_wdata     = wd;
    @(negedge clk);
    cpu_req_valid = 1'b0;

    if (!we && hit) begin
      check("hit_resp", 32'(cpu_resp_valid), 32'd1);
      check("hit_no_mem", 32'(mem_req_valid), 32'd0);
      check("hit_rdata", cpu_rdata, mem_model[addr]);
      return;
    end

    check("mem_req_valid", 32'(mem_req_valid), 32'd1);
    check("mem_we", 32'(mem_we), 32'(we));
    check("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (we) check("mem_wdata", mem_wdata, wd);

    stall = $urandom_range(0, 3);
    repeat (stall) begin
      @(negedge clk);
      check("hold_valid", 32'(mem_req_valid), 32'd1);
      check("hold_addr", 32'(mem_addr), 32'(exp_addr));
      check("hold_we", 32'(mem_we), 32'(we));
      check("no_early_resp", 32'(cpu_resp_valid), 32'd0);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("req_dropped", 32'(mem_req_valid), 32'd0);

    if (we) begin
      check("wr_resp", 32'(cpu_resp_valid), 32'd1);
      check("wr_rdata", cpu_rdata, 32'd0);
      mem_model[addr] = wd;
      return;
    end

    stall = $urandom_range(0, 3);
    repeat (stall) begin
      @(negedge clk);
      check("wait_no_resp", 32'(cpu_resp_valid), 32'd0);
    end
    mem_rvalid = 1'b1;
    drive_line(addr);
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = {4{32'hBAD0BAD0}};
    check("fill_resp", 32'(cpu_resp_valid), 32'd1);
    check("fill_rdata", cpu_rdata, mem_model[addr]);
    model_fill(addr);
  endtask

  initial begin
    int a;
    for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
    model_reset();
    rst = 1'b1;
    cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Read after reset: miss, fill, then hit.
    do_req(1'b0, 'h025, 32'd0);
    do_req(1'b0, 'h025, 32'd0);
`ifdef ASSOC_WT_CACHE_STATS_EN
    @(negedge clk);
    check("stat_hit_first", hit_cnt, 32'd1);
    check("stat_miss_first", miss_cnt, 32'd1);
`endif

    // Write hit then read back.
    do_req(1'b1, 'h026, 32'hDEADBEEF);
    do_req(1'b0, 'h026, 32'd0);
    check("wr_hit_readback", cpu_rdata, 32'hDEADBEEF);

    // Write miss leaves the line absent.
    do_req(1'b1, 'h3F0, 32'h12345678);
    do_req(1'b0, 'h3F0, 32'd0);
    check("wr_miss_readback", cpu_rdata, 32'h12345678);

    // Conflict in set 0.
    do_req(1'b0, 'h000, 32'd0);
    do_req(1'b0, 'h040, 32'd0);
    do_req(1'b0, 'h080, 32'd0);
    do_req(1'b0, 'h040, 32'd0);
    do_req(1'b0, 'h000, 32'd0);

    // Reset while waiting for a line.
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_addr = AW'('h100);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    check("abort_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_mem_valid", 32'(mem_req_valid), 32'd0);
    check("abort_ready", 32'(cpu_req_ready), 32'd1);
    rst = 1'b0;
    model_reset();
    mem_rvalid = 1'b1;
    drive_line('h100);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rvalid_ignored", 32'(cpu_resp_valid), 32'd0);
    check("late_rvalid_ready", 32'(cpu_req_ready), 32'd1);
    do_req(1'b0, 'h100, 32'd0);
    do_req(1'b0, 'h040, 32'd0);

    // Randomized traffic over a small footprint to mix hits, misses, evictions.
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = {4{32'h5A5A5A5A}};
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("stray_rvalid", 32'(cpu_resp_valid), 32'd0);
      end
      do_req($urandom_range(0, 3) == 0, a, $urandom);
    end

`ifdef ASSOC_WT_CACHE_STATS_EN
    @(negedge clk);
    check("stat_hit_final", hit_cnt, 32'(exp_hits));
    check("stat_miss_final", miss_cnt, 32'(exp_misses));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
